// File: rtl/ysyx_22040931_ifu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22040931_ifu_pkg
// Shared definitions for the instruction fetch unit:
//   - ifu_state_e    : 2-bit fetch FSM state encoding
//   - PcResetDefault : PC loaded on reset unless overridden by the top parameter
//   - NopInst        : addi x0, x0, 0, presented on inst while nothing was fetched
// ----------------------------------------------------------------------------
package ysyx_22040931_ifu_pkg;

    localparam logic [31:0] PcResetDefault = 32'h8000_0000;
    localparam logic [31:0] NopInst        = 32'h0000_0013;

    // IDLE : out of reset, nothing issued
    // REQ  : request on the memory channel, waiting for req_ready
    // WAIT : request accepted, one response outstanding
    // HOLD : instruction offered to decode
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StWait = 2'b10,
        StHold = 2'b11
    } ifu_state_e;

endpackage

// File: rtl/ysyx_22040931_pc_reg.sv
// ----------------------------------------------------------------------------
// ysyx_22040931_pc_reg
// Program counter register with next-PC selection.
// Priority: reset > redirect > advance (+4) > hold.
// Ports:
//   i_clk             clock, rising edge
//   i_rst             asynchronous active-high reset, loads PC_RESET
//   i_redirect_valid  load the redirect target
//   i_redirect_pc     redirect target; low two bits are cleared before loading
//   i_advance         step to the next sequential word (wraps modulo 2^XLEN)
//   o_pc              current PC, always word aligned
// ----------------------------------------------------------------------------
module ysyx_22040931_pc_reg #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = XLEN'(32'h8000_0000)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_advance,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_redirect_target;

    // Fetches are always word reads, so a misaligned target is truncated here;
    // the misalign flag is raised by the top.
    assign w_redirect_target = i_redirect_pc & ~XLEN'(3);

    always_comb begin
        w_pc_next = r_pc;
        if (i_redirect_valid) begin
            w_pc_next = w_redirect_target;
        end else if (i_advance) begin
            w_pc_next = r_pc + XLEN'(4);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= PC_RESET;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_22040931_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_22040931_ifu
// Instruction fetch unit. Issues one word read at a time to instruction memory,
// holds the returned word for decode and follows PC redirects from execute.
// Ports:
//   i_clk / i_rst      clock (rising edge) / asynchronous active-high reset
//   o_req_valid        fetch request valid (REQ state)
//   i_req_ready        memory accepts the request
//   o_req_addr         word address of the fetch, bits [1:0] always zero
//   i_resp_valid       read data valid, one per accepted request
//   i_resp_data        instruction word from memory
//   o_inst_valid       instruction offered to decode (HOLD state)
//   i_inst_ready       decode consumes the instruction
//   o_inst / o_inst_pc instruction word and its PC
//   i_redirect_valid   execute requests a PC change
//   i_redirect_pc      new PC
//   o_misalign         one-cycle pulse: last redirect target had bits [1:0] set
// ----------------------------------------------------------------------------
module ysyx_22040931_ifu
    import ysyx_22040931_ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = XLEN'(PcResetDefault)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    // instruction memory request / response
    output logic            o_req_valid,
    input  logic            i_req_ready,
    output logic [XLEN-1:0] o_req_addr,
    input  logic            i_resp_valid,
    input  logic [31:0]     i_resp_data,
    // decode side
    output logic            o_inst_valid,
    input  logic            i_inst_ready,
    output logic [31:0]     o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    // execute side
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_misalign
);

    ifu_state_e      r_state;
    ifu_state_e      w_state_next;
    // Set when the single outstanding response belongs to a superseded PC.
    logic            r_drop;
    logic            w_drop_next;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic            r_misalign;

    logic [XLEN-1:0] w_pc;
    logic            w_req_fire;
    logic            w_advance;
    logic            w_capture;

    // ------------------------------------------------------------------------
    // PC register
    // ------------------------------------------------------------------------
    ysyx_22040931_pc_reg #(
        .XLEN     (XLEN),
        .PC_RESET (PC_RESET)
    ) u_pc_reg (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .i_advance        (w_advance),
        .o_pc             (w_pc)
    );

    assign w_req_fire = o_req_valid & i_req_ready;

    // A redirect wins over the handshake: the held word is not handed over and
    // the PC does not step.
    assign w_advance = (r_state == StHold) & i_inst_ready & ~i_redirect_valid;

    // A response arriving together with a redirect is stale as well.
    assign w_capture = (r_state == StWait) & i_resp_valid & ~r_drop & ~i_redirect_valid;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_drop  <= w_drop_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        unique case (r_state)
            StIdle: begin
                w_state_next = StReq;
            end
            StReq: begin
                // A redirect here only retargets the PC; if the old address was
                // accepted in the same cycle its response must be thrown away.
                if (w_req_fire) begin
                    w_state_next = StWait;
                    w_drop_next  = i_redirect_valid;
                end
            end
            StWait: begin
                if (i_resp_valid) begin
                    w_state_next = w_capture ? StHold : StReq;
                    w_drop_next  = 1'b0;
                end else if (i_redirect_valid) begin
                    w_drop_next = 1'b1;
                end
            end
            StHold: begin
                if (i_redirect_valid || i_inst_ready) begin
                    w_state_next = StReq;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_drop_next  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: Moore outputs
    // ------------------------------------------------------------------------
    always_comb begin
        o_req_valid  = 1'b0;
        o_inst_valid = 1'b0;
        unique case (r_state)
            StReq:   o_req_valid  = 1'b1;
            StHold:  o_inst_valid = 1'b1;
            default: begin
                o_req_valid  = 1'b0;
                o_inst_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Instruction holding registers and misalign pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inst     <= NopInst;
            r_inst_pc  <= PC_RESET;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= i_redirect_valid & (|i_redirect_pc[1:0]);
            if (w_capture) begin
                r_inst    <= i_resp_data;
                r_inst_pc <= w_pc;
            end
        end
    end

    assign o_req_addr = w_pc;
    assign o_inst     = r_inst;
    assign o_inst_pc  = r_inst_pc;
    assign o_misalign = r_misalign;

endmodule
